// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and byte-enable helper for lsu_align
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LDATA = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for a store of the given size at the given byte offset
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align_load_extend.sv
// rtl/lsu_align_load_extend.sv - select byte/half from a read word and sign/zero-extend it
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend by access size
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit in front of a word-addressed data memory
module lsu_align
  import lsu_pkg::*;
#(
  parameter int AW   = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state_q, state_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  logic            legal, aligned, ok, accept;
  logic [XLEN-1:0] ld_data;

  load_extend u_ext (
    .word   (mem_rd),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // Request decode and memory drive; memory is only touched from IDLE on a good store
  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~req_we;
      default:          legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    ok        = legal & aligned;
    req_ready = (state_q == IDLE) & ~reset;
    accept    = req_valid & req_ready;
    mem_addr  = {req_addr[AW-1:2], 2'b00};
    mem_we    = accept & req_we & ok;
    mem_be    = mem_we ? be_gen(req_funct3, req_addr[1:0]) : 4'b0000;
    mem_wd    = req_wdata << {req_addr[1:0], 3'b000};
  end

  // Next-state and response computation
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    off_d        = off_q;
    f3_d         = f3_q;
    we_d         = we_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          we_d  = req_we;
          err_d = ~ok;
          if (!req_we && ok) begin
            state_d = LDATA;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
          end
        end
      end
      LDATA: begin
        resp_data_d  = we_q ? '0 : ld_data;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = err_q;

endmodule
